// File: rtl/id_decode_buf.sv
// id_decode_buf: decode-stage front end with a two-entry skid buffer; optional id_illegal via ILLEGAL_INST_DET_EN
module id_decode_buf #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_inst,
    input  logic [31:0] if_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [24:0] id_imm_in,
    output logic [2:0]  id_inst_type,
    output logic        id_shift_imm,
    output logic [6:0]  id_opcode,
    output logic [2:0]  id_funct3,
    output logic [6:0]  id_funct7,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [31:0] id_pc
`ifdef ILLEGAL_INST_DET_EN
    ,
    output logic        id_illegal
`endif
);
    localparam logic [2:0] INST_R    = 3'd0;
    localparam logic [2:0] INST_I    = 3'd1;
    localparam logic [2:0] INST_S    = 3'd2;
    localparam logic [2:0] INST_B    = 3'd3;
    localparam logic [2:0] INST_U    = 3'd4;
    localparam logic [2:0] INST_J    = 3'd5;
    localparam logic [2:0] INST_NONE = 3'd7;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [2:0]  typ;
        logic        shift;
`ifdef ILLEGAL_INST_DET_EN
        logic        illegal;
`endif
    } entry_t;

    entry_t dec;
    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   accept;
    logic   drain;
    logic [6:0] op;
    logic [2:0] f3;

    assign op       = if_inst[6:0];
    assign f3       = if_inst[14:12];
    assign if_ready = ~skid_valid_q;
    assign id_valid = out_valid_q;
    assign accept   = if_valid & if_ready;
    assign drain    = out_valid_q & id_ready;

    // Classify the incoming word so it can be captured alongside the raw bits
    always_comb begin
        dec       = '0;
        dec.inst  = if_inst;
        dec.pc    = if_pc;
        dec.typ   = (op == 7'b0110111 || op == 7'b0010111) ? INST_U :
                    (op == 7'b1101111) ? INST_J :
                    (op == 7'b1100111 || op == 7'b0000011 || op == 7'b0010011 ||
                     op == 7'b0001111 || op == 7'b1110011) ? INST_I :
                    (op == 7'b1100011) ? INST_B :
                    (op == 7'b0100011) ? INST_S :
                    (op == 7'b0110011) ? INST_R : INST_NONE;
        dec.shift = (op == 7'b0010011) && (f3 == 3'b001 || f3 == 3'b101);
`ifdef ILLEGAL_INST_DET_EN
        dec.illegal = (dec.typ == INST_NONE) || (if_inst[1:0] != 2'b11) ||
                      (op == 7'b0110011 && if_inst[31:25] != 7'b0000000 && if_inst[31:25] != 7'b0100000);
`endif
    end

    // Skid-buffer steering: output register refills from skid first, then from fetch
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || drain) begin
            out_valid_d  = skid_valid_q | accept;
            out_d        = skid_valid_q ? skid_q : accept ? dec : out_q;
            skid_valid_d = 1'b0;
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_d       = dec;
        end
    end

    // State registers; reset clears both entries and the presented payload
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            out_q.typ    <= INST_NONE;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
        end
    end

    assign id_imm_in    = out_q.inst[31:7];
    assign id_opcode    = out_q.inst[6:0];
    assign id_rd        = out_q.inst[11:7];
    assign id_funct3    = out_q.inst[14:12];
    assign id_rs1       = out_q.inst[19:15];
    assign id_rs2       = out_q.inst[24:20];
    assign id_funct7    = out_q.inst[31:25];
    assign id_inst_type = out_q.typ;
    assign id_shift_imm = out_q.shift;
    assign id_pc        = out_valid_q ? out_q.pc : RESET_PC;
`ifdef ILLEGAL_INST_DET_EN
    assign id_illegal   = out_q.illegal;
`endif
endmodule
